seq_multdiv: RTL

- Multi-cycle signed multiply/divide unit that sits beside the single-cycle add/sub ALU in the execute stage.
- The pipeline issues a one-cycle start strobe together with the operands. The unit iterates one bit per clock, then returns the result with a one-cycle ready pulse. The processor stalls on busy.
- It shares the 32-bit two's-complement datapath conventions of the ALU.
- Exception reporting mirrors the ALU overflow flag.

---
 rtl/seq_multdiv.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seq_multdiv.sv
// rtl/seq_multdiv.sv - multi-cycle signed multiply/divide unit, one bit per clock
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign applied at completion.
module seq_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg;
    logic             div_zero;
    // hi: partial product upper half / remainder; lo: multiplier / quotient bits
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   opb;

    logic             start;
    logic             accept;
    logic             last;

    logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_t;
    logic               div_ge;
    logic [WIDTH:0]     div_r;
    logic [2*WIDTH-1:0] mag_p;
    logic [2*WIDTH-1:0] prod;
    logic               mul_exc;
    logic [WIDTH-1:0]   quot;
    logic               div_exc;

    assign start  = ctrl_MULT | ctrl_DIV;
    assign accept = start && (state != RUN);
    assign last   = (count == CW'(WIDTH));

    assign data_resultRDY = (state == DONE);
    assign busy           = (state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One extra bit keeps the magnitude of the most-negative operand exact
    always_comb begin
        a_ext = {data_operandA[WIDTH-1], data_operandA};
        b_ext = {data_operandB[WIDTH-1], data_operandB};
        a_mag = data_operandA[WIDTH-1] ? -a_ext : a_ext;
        b_mag = data_operandB[WIDTH-1] ? -b_ext : b_ext;
    end

    always_comb begin
        mul_sum = hi + (lo[0] ? opb : '0);
        div_t   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_ge  = (div_t >= opb);
        div_r   = div_ge ? (div_t - opb) : div_t;
        mag_p   = {hi[WIDTH-1:0], lo};
        prod    = neg ? -mag_p : mag_p;
        mul_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        quot    = neg ? -lo : lo;
        // A positive quotient of 2^(WIDTH-1) only arises from most-negative / -1
        div_exc = div_zero || (lo[WIDTH-1] && !neg);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count          <= '0;
            op_div         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            hi             <= '0;
            lo             <= '0;
            opb            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            op_div   <= !ctrl_MULT;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            hi       <= '0;
            if (ctrl_MULT) begin
                lo  <= b_mag[WIDTH-1:0];
                opb <= a_mag;
            end else begin
                lo  <= a_mag[WIDTH-1:0];
                opb <= b_mag;
            end
        end else if (state == RUN) begin
            if (!last) begin
                count <= count + 1'b1;
                if (op_div) begin
                    hi <= div_r;
                    lo <= {lo[WIDTH-2:0], div_ge};
                end else begin
                    hi <= {1'b0, mul_sum[WIDTH:1]};
                    lo <= {mul_sum[0], lo[WIDTH-1:1]};
                end
            end else if (op_div) begin
                data_result    <= div_zero ? '0 : quot;
                data_exception <= div_exc;
            end else begin
                data_result    <= prod[WIDTH-1:0];
                data_exception <= mul_exc;
            end
        end
    end

endmodule
